apb_seq_controller: RTL and testbench
=====================================

APB_SEQ_CONTROLLER -- requirements
Module: apb_seq_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum number of ENABLE cycles with Pready low before abort (used only with APB_WAIT_STATE_EN).
REQ-002 SHALL have port Hclk, input, 1, the single clock; all flops update on its rising edge.
REQ-003 SHALL have port Hreset, input, 1, the reset: synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1, a transfer request is present.
REQ-005 SHALL have port req_ready, output, 1, the controller accepts a request this cycle.
REQ-006 SHALL have port req_write, input, 1, request direction: 1=write, 0=read.
REQ-007 SHALL have port req_addr, input, 32, request address.
REQ-008 SHALL have port req_wdata, input, 32, request write data.
REQ-009 SHALL have port Pready, input, 1, slave ready; present only with APB_WAIT_STATE_EN.
REQ-010 SHALL have port PRdata, input, 32, APB read data.
REQ-011 SHALL have port Pselx, output, 3, one-hot slave select.
REQ-012 SHALL have port Penable, output, 1, APB enable.
REQ-013 SHALL have port Pwrite, output, 1, APB direction.
REQ-014 SHALL have port Paddr, output, 32, APB address.
REQ-015 SHALL have port PWdata, output, 32, APB write data.
REQ-016 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-017 SHALL have port rsp_err, output, 1, completion was a decode miss or timeout; qualified by rsp_valid.
REQ-018 SHALL have port rsp_rdata, output, 32, read data; qualified by rsp_valid.

Function
REQ-019 SHALL implement the states IDLE, SETUP, ENABLE and ERR.
REQ-020 SHALL assert req_ready only in IDLE; accept = req_valid && req_ready at a rising edge, which captures req_write, req_addr and req_wdata.
REQ-021 SHALL decode the captured address: 0x8000_0000-0x83FF_FFFF -> Pselx=3'b001; 0x8400_0000-0x87FF_FFFF -> 3'b010; 0x8800_0000-0x8BFF_FFFF -> 3'b100; any other address is a miss.
REQ-022 SHALL transition IDLE->SETUP on accept with a decode hit, and IDLE->ERR on accept with a decode miss.
REQ-023 SHALL in SETUP drive Pselx to the decoded value with Penable=0, then always go to ENABLE.
REQ-024 SHALL in ENABLE drive Pselx held and Penable=1; completion occurs in ENABLE when Pready=1 (without the macro, completion occurs in the first ENABLE cycle); on completion go to IDLE.
REQ-025 SHALL hold Paddr, Pwrite and PWdata stable from SETUP through the end of ENABLE; in IDLE and ERR they hold their last values and Pselx=0, Penable=0.
REQ-026 SHALL spend exactly one cycle in ERR, with no APB activity, then go to IDLE.
REQ-027 SHALL register rsp_valid, rsp_err and rsp_rdata, pulsing rsp_valid for exactly one cycle in the cycle after completion or after the ERR cycle.
REQ-028 SHALL set rsp_rdata=PRdata sampled at completion for reads, and rsp_rdata=0 for writes and errors.
REQ-029 SHALL have a no-wait-state latency of: accept edge k -> SETUP in k+1 -> ENABLE in k+2 -> rsp_valid in k+3.
REQ-030 SHALL allow a new accept in the same cycle that rsp_valid is high, since the FSM is already in IDLE.
REQ-031 SHALL ignore req_valid outside IDLE; the requester must hold its request until req_ready.

Reset
REQ-032 SHALL, when Hreset=1 at a rising edge in any state, go to IDLE and drive Pselx=0, Penable=0, Pwrite=0, Paddr=0, PWdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0 and clear the wait counter.
REQ-033 SHALL discard any in-flight transfer on reset mid-operation and generate no rsp_valid for it.
REQ-034 SHALL hold req_ready=0 while Hreset=1.

Configuration
REQ-035 SHALL, with APB_WAIT_STATE_EN defined, provide the Pready port and a wait counter that counts ENABLE cycles with Pready=0.
REQ-036 SHALL, with APB_WAIT_STATE_EN defined, abort to IDLE when the counter reaches TIMEOUT_CYCLES, drop Pselx/Penable, and report rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-037 SHALL, without APB_WAIT_STATE_EN, omit the Pready port and the counter, with ENABLE always lasting exactly one cycle.

Structure
REQ-038 SHALL place in shared package apb_ctrl_pkg: the state enum, the slave base/limit address constants, the Pselx one-hot codes and the TIMEOUT_CYCLES default.
REQ-039 SHALL implement the address decode as a combinational sub-module apb_addr_decode (addr in; sel[2:0] and miss out).

Verification
REQ-040 SHALL verify a write: write 0x8000_0010 with data 0xDEAD_BEEF -> SETUP with Pselx=001, Penable=0; ENABLE with Penable=1, PWdata=0xDEAD_BEEF; rsp_valid at k+3 with rsp_err=0.
REQ-041 SHALL verify a read: read 0x8400_0004 with PRdata=0x1234_5678 -> Pselx=010 and rsp_rdata=0x1234_5678 at k+3.
REQ-042 SHALL verify a decode miss: read 0x9000_0000 -> Pselx stays 0, ERR for one cycle, then rsp_valid with rsp_err=1 at k+2.
REQ-043 SHALL verify back-to-back requests: req_valid held with two requests -> second accept in the rsp_valid cycle, and Penable is never high for two transfers without an intervening SETUP.
REQ-044 SHALL verify wait states (macro on): Pready=0 for 3 cycles -> ENABLE lasts 4 cycles; Pready=0 for 16 cycles -> abort with rsp_err=1.
REQ-045 SHALL verify reset mid-operation: Hreset=1 during ENABLE -> all outputs 0 at the next edge and no rsp_valid for the aborted transfer.

Source files
------------

// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the APB sequential controller: FSM states,
// slave address windows, one-hot select codes and the default wait timeout.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ENABLE,
    ST_ERR
  } apb_state_t;

  localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
  localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
  localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
  localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_SLV0 = 3'b001;
  localparam logic [2:0] SEL_SLV1 = 3'b010;
  localparam logic [2:0] SEL_SLV2 = 3'b100;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: maps an address onto a one-hot slave
// select, flagging addresses outside every slave window as a miss.
module apb_addr_decode
  import apb_ctrl_pkg::*;
(
  input  logic [31:0] addr,
  output logic [2:0]  sel,
  output logic        miss
);

  always_comb begin
    sel = SEL_NONE;
    if (in_range(addr, SLV0_BASE, SLV0_LIMIT))      sel = SEL_SLV0;
    else if (in_range(addr, SLV1_BASE, SLV1_LIMIT)) sel = SEL_SLV1;
    else if (in_range(addr, SLV2_BASE, SLV2_LIMIT)) sel = SEL_SLV2;
  end

  assign miss = (sel == SEL_NONE);

endmodule

// File: rtl/apb_seq_controller.sv
// Request/response front end that sequences single APB transfers.
// Define APB_WAIT_STATE_EN to add the Pready input and wait-state timeout.
module apb_seq_controller
  import apb_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef APB_WAIT_STATE_EN
  input  logic        Pready,
`endif
  input  logic [31:0] PRdata,
  output logic [2:0]  Pselx,
  output logic        Penable,
  output logic        Pwrite,
  output logic [31:0] Paddr,
  output logic [31:0] PWdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata
);

  if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_t  r_state;
  logic [2:0]  r_pselx;
  logic        r_penable;
  logic        r_pwrite;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic        r_rspValid;
  logic        r_rspErr;
  logic [31:0] r_rspRdata;

  logic [2:0]  w_sel;
  logic        w_miss;
  logic        w_done;
  logic        w_timeout;

  apb_addr_decode u_decode (
    .addr (req_addr),
    .sel  (w_sel),
    .miss (w_miss)
  );

`ifdef APB_WAIT_STATE_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_waitCnt;

  // The abort fires on the ENABLE cycle that would be the TIMEOUT_CYCLES-th one stalled
  assign w_done    = Pready;
  assign w_timeout = !Pready && (r_waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Hclk) begin
    if (Hreset)
      r_waitCnt <= '0;
    else if (r_state == ST_ENABLE && !Pready && !w_timeout)
      r_waitCnt <= r_waitCnt + 1'b1;
    else
      r_waitCnt <= '0;
  end
`else
  assign w_done    = 1'b1;
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_state    <= ST_IDLE;
      r_pselx    <= SEL_NONE;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_rspValid <= 1'b0;
      r_rspErr   <= 1'b0;
      r_rspRdata <= '0;
    end else begin
      r_rspValid <= 1'b0;
      r_rspErr   <= 1'b0;
      r_rspRdata <= '0;
      case (r_state)
        ST_IDLE: begin
          // A miss never reaches the bus, so the APB address/data keep their old values
          if (req_valid) begin
            if (w_miss) begin
              r_state <= ST_ERR;
            end else begin
              r_state  <= ST_SETUP;
              r_pselx  <= w_sel;
              r_pwrite <= req_write;
              r_paddr  <= req_addr;
              r_pwdata <= req_wdata;
            end
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ENABLE;
        end
        ST_ENABLE: begin
          if (w_done || w_timeout) begin
            r_state    <= ST_IDLE;
            r_pselx    <= SEL_NONE;
            r_penable  <= 1'b0;
            r_rspValid <= 1'b1;
            r_rspErr   <= w_timeout;
            r_rspRdata <= (w_done && !r_pwrite) ? PRdata : '0;
          end
        end
        ST_ERR: begin
          r_state    <= ST_IDLE;
          r_rspValid <= 1'b1;
          r_rspErr   <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE) && !Hreset;
  assign Pselx     = r_pselx;
  assign Penable   = r_penable;
  assign Pwrite    = r_pwrite;
  assign Paddr     = r_paddr;
  assign PWdata    = r_pwdata;
  assign rsp_valid = r_rspValid;
  assign rsp_err   = r_rspErr;
  assign rsp_rdata = r_rspRdata;

endmodule

// File: tb/tb_apb_seq_controller.sv
// Self-checking bench for apb_seq_controller: a cycle-schedule model predicts
// every output each cycle, with directed literal checks pinning that model.
module tb_apb_seq_controller;

  localparam int TO = 16;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] PRdata;
`ifdef APB_WAIT_STATE_EN
  logic        Pready = 1'b1;
`endif
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] PWdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 Hclk = ~Hclk;

  apb_seq_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef APB_WAIT_STATE_EN
    .Pready    (Pready),
`endif
    .PRdata    (PRdata),
    .Pselx     (Pselx),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Paddr     (Paddr),
    .PWdata    (PWdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata)
  );

  // One expected record per clock cycle; a transfer is expanded into its
  // whole cycle timeline at the moment it is accepted.
  typedef struct {
    logic [2:0]  sel;
    logic        en;
    logic        rv;
    logic        rerr;
    logic [31:0] rdata;
    logic        ready;
    logic        pready;
    logic        complete;
    logic        isRead;
  } cyc_t;

  cyc_t        expQ[$];
  cyc_t        cur;
  logic [31:0] expAddr;
  logic [31:0] expWdata;
  logic        expWrite;
  int          reqWaits = 0;
  logic        fixPrd = 1'b0;
  logic [31:0] fixVal = '0;
  logic        rvSeen;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cyc_t idleRec();
    cyc_t r;
    r.sel = 3'b000; r.en = 1'b0; r.rv = 1'b0; r.rerr = 1'b0; r.rdata = '0;
    r.ready = 1'b1; r.pready = 1'b1; r.complete = 1'b0; r.isRead = 1'b0;
    return r;
  endfunction

  // Each slave owns a 64 MiB window starting at 0x8000_0000
  function automatic logic [2:0] modelSel(input logic [31:0] a);
    int idx;
    if (a < 32'h8000_0000) return 3'b000;
    idx = int'((a - 32'h8000_0000) >> 26);
    if (idx > 2) return 3'b000;
    return 3'(1 << idx);
  endfunction

  function automatic void scheduleTransfer(input logic w, input logic [31:0] a,
                                           input logic [31:0] d, input int waits);
    cyc_t r;
    logic [2:0] sel;
    logic timeout;
    int nEn;
    sel = modelSel(a);
    if (sel == 3'b000) begin
      r = idleRec(); r.ready = 1'b0; expQ.push_back(r);
      r = idleRec(); r.rv = 1'b1; r.rerr = 1'b1; expQ.push_back(r);
      return;
    end
    expAddr = a; expWrite = w; expWdata = d;
`ifdef APB_WAIT_STATE_EN
    timeout = (waits >= TO);
    nEn = timeout ? TO : waits + 1;
`else
    timeout = 1'b0;
    nEn = 1;
`endif
    r = idleRec(); r.ready = 1'b0; r.sel = sel; expQ.push_back(r);
    for (int i = 0; i < nEn; i++) begin
      r = idleRec(); r.ready = 1'b0; r.sel = sel; r.en = 1'b1;
      r.pready = (i >= waits);
      r.complete = !timeout && (i == nEn - 1);
      r.isRead = !w;
      expQ.push_back(r);
    end
    r = idleRec(); r.rv = 1'b1; r.rerr = timeout; expQ.push_back(r);
  endfunction

  // Model advances on each rising edge, then compares all outputs 1 time unit later
  initial begin
    cyc_t tmp;
    logic accept;
    cur = idleRec();
    expAddr = '0; expWrite = 1'b0; expWdata = '0;
    forever begin
      @(posedge Hclk);
      if (Hreset) begin
        expQ.delete();
        cur = idleRec();
        expAddr = '0; expWrite = 1'b0; expWdata = '0;
      end else begin
        accept = cur.ready && req_valid;
        if (cur.complete && cur.isRead && expQ.size() > 0) begin
          tmp = expQ[0]; tmp.rdata = PRdata; expQ[0] = tmp;
        end
        if (accept) scheduleTransfer(req_write, req_addr, req_wdata, reqWaits);
        if (expQ.size() > 0) cur = expQ.pop_front();
        else cur = idleRec();
      end
      #1;
      checkOutput("model Pselx", 32'(Pselx), 32'(cur.sel));
      checkOutput("model Penable", 32'(Penable), 32'(cur.en));
      checkOutput("model rsp_valid", 32'(rsp_valid), 32'(cur.rv));
      checkOutput("model req_ready", 32'(req_ready), 32'(cur.ready && !Hreset));
      checkOutput("model Paddr", Paddr, expAddr);
      checkOutput("model Pwrite", 32'(Pwrite), 32'(expWrite));
      checkOutput("model PWdata", PWdata, expWdata);
      if (cur.rv) begin
        checkOutput("model rsp_err", 32'(rsp_err), 32'(cur.rerr));
        checkOutput("model rsp_rdata", rsp_rdata, cur.rdata);
      end
    end
  end

  // Slave side: fresh read data every cycle, Pready from the scheduled wait count
  always @(negedge Hclk) begin
    PRdata = fixPrd ? fixVal : $urandom;
`ifdef APB_WAIT_STATE_EN
    Pready = cur.pready;
`endif
  end

  // Called at a falling edge; returns at the falling edge after the accept
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input int waits);
    int budget = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; reqWaits = waits;
    while (!req_ready && budget < 100) begin
      @(negedge Hclk);
      budget++;
    end
    if (!req_ready) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL handshake: req_ready stayed 0, expected 1 within 100 cycles");
      rvSeen = 1'b0;
    end else begin
      rvSeen = rsp_valid;
      @(negedge Hclk);
    end
    req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int budget = 0;
    while (!req_ready && budget < 100) begin
      @(negedge Hclk);
      budget++;
    end
  endtask

`ifdef APB_WAIT_STATE_EN
  task automatic measureWaits(input int waits, input int expEn, input logic expErr);
    int en = 0;
    int budget = 0;
    logic sawRsp = 1'b0;
    applyStimulus(1'b1, 32'h8400_0100, 32'h0000_00AA + 32'(waits), waits);
    while (!sawRsp && budget < 60) begin
      @(negedge Hclk);
      budget++;
      if (rsp_valid) sawRsp = 1'b1;
      else if (Penable) en++;
    end
    checkOutput($sformatf("wait%0d enable cycles", waits), 32'(en), 32'(expEn));
    checkOutput($sformatf("wait%0d rsp_err", waits), 32'(rsp_err && sawRsp), 32'(expErr));
  endtask
`endif

  function automatic logic [31:0] randAddr();
    logic [31:0] base;
    logic [31:0] off;
    base = 32'h8000_0000 + (32'($urandom_range(0, 2)) << 26);
    case ($urandom_range(0, 3))
      0: off = 32'h0000_0000;
      1: off = 32'h03FF_FFFF;
      default: off = $urandom & 32'h03FF_FFFC;
    endcase
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8C00_0000;
      2: return $urandom;
      default: return base + off;
    endcase
  endfunction

  initial begin
    int rvCount;
    int waits;
    Hreset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge Hclk);
    checkOutput("reset Pselx", 32'(Pselx), 32'h0);
    checkOutput("reset Paddr", Paddr, 32'h0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset req_ready", 32'(req_ready), 32'h0);
    Hreset = 1'b0;
    @(negedge Hclk);

    applyStimulus(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 0);
    checkOutput("wr setup Pselx", 32'(Pselx), 32'h1);
    checkOutput("wr setup Penable", 32'(Penable), 32'h0);
    @(negedge Hclk);
    checkOutput("wr enable Penable", 32'(Penable), 32'h1);
    checkOutput("wr enable PWdata", PWdata, 32'hDEAD_BEEF);
    @(negedge Hclk);
    checkOutput("wr rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("wr rsp_err", 32'(rsp_err), 32'h0);

    @(negedge Hclk);
    fixPrd = 1'b1; fixVal = 32'h1234_5678;
    applyStimulus(1'b0, 32'h8400_0004, 32'h0, 0);
    checkOutput("rd setup Pselx", 32'(Pselx), 32'h2);
    @(negedge Hclk);
    @(negedge Hclk);
    checkOutput("rd rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("rd rsp_rdata", rsp_rdata, 32'h1234_5678);
    fixPrd = 1'b0;

    @(negedge Hclk);
    applyStimulus(1'b0, 32'h9000_0000, 32'h0, 0);
    checkOutput("miss err-cycle Pselx", 32'(Pselx), 32'h0);
    checkOutput("miss err-cycle req_ready", 32'(req_ready), 32'h0);
    @(negedge Hclk);
    checkOutput("miss rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("miss rsp_err", 32'(rsp_err), 32'h1);
    checkOutput("miss rsp_rdata", rsp_rdata, 32'h0);

    @(negedge Hclk);
    applyStimulus(1'b1, 32'h8800_0000, 32'hA5A5_5A5A, 0);
    applyStimulus(1'b0, 32'h8BFF_FFFC, 32'h0, 0);
    checkOutput("b2b second accept in rsp cycle", 32'(rvSeen), 32'h1);
    checkOutput("b2b second setup Penable", 32'(Penable), 32'h0);
    waitIdle();

`ifdef APB_WAIT_STATE_EN
    measureWaits(3, 4, 1'b0);
    waitIdle();
    measureWaits(TO - 1, TO, 1'b0);
    waitIdle();
    measureWaits(TO, TO, 1'b1);
    waitIdle();
`endif

    applyStimulus(1'b1, 32'h8000_0100, 32'h0000_0011, 0);
    @(negedge Hclk);
    checkOutput("rst-mid Penable before", 32'(Penable), 32'h1);
    Hreset = 1'b1;
    @(posedge Hclk);
    #2;
    checkOutput("rst-mid Pselx", 32'(Pselx), 32'h0);
    checkOutput("rst-mid Penable", 32'(Penable), 32'h0);
    checkOutput("rst-mid Paddr", Paddr, 32'h0);
    checkOutput("rst-mid PWdata", PWdata, 32'h0);
    checkOutput("rst-mid rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge Hclk);
    Hreset = 1'b0;
    rvCount = 0;
    repeat (5) begin
      @(negedge Hclk);
      if (rsp_valid) rvCount++;
    end
    checkOutput("rst-mid no response", 32'(rvCount), 32'h0);

    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge Hclk);
      waits = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 1, TO + 2))
                                          : int'($urandom_range(0, 3));
      applyStimulus(1'($urandom), randAddr(), $urandom, waits);
    end
    waitIdle();
    repeat (4) @(negedge Hclk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
